// File: rtl/priv_mem_arbiter.sv
// priv_mem_arbiter: shares one single-port memory between a user and an admin requester with privilege checks
// Ports: clk, reset (sync, active-high); usr_*/adm_* request, grant and response channels;
//        mem_* single-port memory interface (mem_rdata valid the cycle after mem_en).
// Optional: define ACCESS_LOG_EN to add viol_count/viol_addr denial logging outputs.
module priv_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] PROT_LIMIT = 'h40,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  usr_req,
  input  logic                  usr_we,
  input  logic [ADDR_WIDTH-1:0] usr_addr,
  input  logic [DATA_WIDTH-1:0] usr_wdata,
  output logic                  usr_gnt,
  output logic                  usr_rvalid,
  output logic [DATA_WIDTH-1:0] usr_rdata,
  output logic                  usr_err,
  input  logic                  adm_req,
  input  logic                  adm_we,
  input  logic [ADDR_WIDTH-1:0] adm_addr,
  input  logic [DATA_WIDTH-1:0] adm_wdata,
  output logic                  adm_gnt,
  output logic                  adm_rvalid,
  output logic [DATA_WIDTH-1:0] adm_rdata,
  output logic                  adm_err,
`ifdef ACCESS_LOG_EN
  output logic [7:0]            viol_count,
  output logic [ADDR_WIDTH-1:0] viol_addr,
`endif
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t                state_q, state_d;
  logic                  win_adm_q, win_adm_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  any_req, usr_wins, starved, permitted, acc, rsp;
  logic [DATA_WIDTH-1:0] rdata_v;
  assign any_req   = usr_req | adm_req;
  assign starved   = starve_q == SW'(STARVE_MAX);
  // admin wins ties unless the user has been passed over STARVE_MAX times in a row
  assign usr_wins  = usr_req & (~adm_req | starved);
  assign permitted = win_adm_q | (addr_q >= PROT_LIMIT);
  assign acc       = state_q == ACCESS;
  assign rsp       = state_q == RESP;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      win_adm_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      win_adm_q <= win_adm_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (any_req ? ACCESS : IDLE) : state_q == ACCESS ? RESP : IDLE;
  end
  always_comb begin
    win_adm_d = win_adm_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    if (state_q == IDLE && any_req) begin
      win_adm_d = ~usr_wins;
      we_d      = usr_wins ? usr_we : adm_we;
      addr_d    = usr_wins ? usr_addr : adm_addr;
      wdata_d   = usr_wins ? usr_wdata : adm_wdata;
      starve_d  = usr_wins ? '0 : (usr_req && !starved) ? starve_q + 1'b1 : starve_q;
    end
  end
  // denied accesses keep mem_en low so the memory never sees them
  always_comb begin
    usr_gnt    = acc & ~win_adm_q;
    adm_gnt    = acc & win_adm_q;
    usr_rvalid = rsp & ~win_adm_q;
    adm_rvalid = rsp & win_adm_q;
    usr_err    = usr_rvalid & ~permitted;
    adm_err    = adm_rvalid & ~permitted;
    mem_en     = acc & permitted;
    mem_we     = mem_en & we_q;
    mem_addr   = mem_en ? addr_q : '0;
    mem_wdata  = mem_en ? wdata_q : '0;
    rdata_v    = (rsp && permitted && !we_q) ? mem_rdata : '0;
    usr_rdata  = usr_rvalid ? rdata_v : '0;
    adm_rdata  = adm_rvalid ? rdata_v : '0;
  end
`ifdef ACCESS_LOG_EN
  logic [7:0]            viol_count_q;
  logic [ADDR_WIDTH-1:0] viol_addr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      viol_count_q <= '0;
      viol_addr_q  <= '0;
    end else if (rsp && !permitted) begin
      viol_count_q <= viol_count_q + {7'd0, viol_count_q != 8'hFF};
      viol_addr_q  <= addr_q;
    end
  end
  assign viol_count = viol_count_q;
  assign viol_addr  = viol_addr_q;
`endif
endmodule
